// File: rtl/time_digit_decoder.sv
// time_digit_decoder: converts a remaining-time value in whole seconds into
// four registered BCD digits (MM:SS) by repeated subtraction of 600, 60 and 10.
// A conversion starts whenever time_in differs from the last converted value.
// Any value of 6000 s or more saturates the display at 99:59 and sets overflow.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   time_in   - remaining time in seconds (TIME_W bits)
//   min_tens  - minutes tens digit, BCD 0..9
//   min_units - minutes units digit, BCD 0..9
//   sec_tens  - seconds tens digit, BCD 0..5
//   sec_units - seconds units digit, BCD 0..9
//   valid     - one-cycle pulse when the digit outputs are updated
//   busy      - high while a conversion is in progress
//   overflow  - last converted value was 6000 s or more
//   zero      - last converted value was 0
module time_digit_decoder #(
  parameter int unsigned TIME_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] time_in,
  output logic [3:0]        min_tens,
  output logic [3:0]        min_units,
  output logic [3:0]        sec_tens,
  output logic [3:0]        sec_units,
  output logic              valid,
  output logic              busy,
  output logic              overflow,
  output logic              zero
);

  localparam int unsigned DIG_W = 4;

  localparam logic [TIME_W-1:0] OVF_LIMIT = TIME_W'(6000);
  localparam logic [TIME_W-1:0] STEP_600  = TIME_W'(600);
  localparam logic [TIME_W-1:0] STEP_60   = TIME_W'(60);
  localparam logic [TIME_W-1:0] STEP_10   = TIME_W'(10);
  localparam logic [TIME_W-1:0] TIME_ZERO = TIME_W'(0);

  localparam logic [DIG_W-1:0] DIG_ZERO = DIG_W'(0);
  localparam logic [DIG_W-1:0] DIG_ONE  = DIG_W'(1);
  localparam logic [DIG_W-1:0] DIG_FIVE = DIG_W'(5);
  localparam logic [DIG_W-1:0] DIG_NINE = DIG_W'(9);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUB600 = 3'd1,
    SUB60  = 3'd2,
    SUB10  = 3'd3,
    COMMIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Working registers of the conversion
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic [DIG_W-1:0]  mt_q, mt_d;
  logic [DIG_W-1:0]  mu_q, mu_d;
  logic [DIG_W-1:0]  st_q, st_d;

  // Committed outputs
  logic [DIG_W-1:0]  min_tens_q, min_tens_d;
  logic [DIG_W-1:0]  min_units_q, min_units_d;
  logic [DIG_W-1:0]  sec_tens_q, sec_tens_d;
  logic [DIG_W-1:0]  sec_units_q, sec_units_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= TIME_ZERO;
      last_time_q <= TIME_ZERO;
      mt_q        <= DIG_ZERO;
      mu_q        <= DIG_ZERO;
      st_q        <= DIG_ZERO;
      min_tens_q  <= DIG_ZERO;
      min_units_q <= DIG_ZERO;
      sec_tens_q  <= DIG_ZERO;
      sec_units_q <= DIG_ZERO;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      last_time_q <= last_time_d;
      mt_q        <= mt_d;
      mu_q        <= mu_d;
      st_q        <= st_d;
      min_tens_q  <= min_tens_d;
      min_units_q <= min_units_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    last_time_d = last_time_q;
    mt_d        = mt_q;
    mu_d        = mu_q;
    st_d        = st_q;
    min_tens_d  = min_tens_q;
    min_units_d = min_units_q;
    sec_tens_d  = sec_tens_q;
    sec_units_d = sec_units_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (time_in != last_time_q) begin
          rem_d       = time_in;
          last_time_d = time_in;
          mt_d        = DIG_ZERO;
          mu_d        = DIG_ZERO;
          st_d        = DIG_ZERO;
          busy_d      = 1'b1;
          // Saturating values skip the subtraction chain entirely
          state_d     = (time_in >= OVF_LIMIT) ? COMMIT : SUB600;
        end
      end
      SUB600: begin
        if (rem_q >= STEP_600) begin
          rem_d = rem_q - STEP_600;
          mt_d  = mt_q + DIG_ONE;
        end else begin
          state_d = SUB60;
        end
      end
      SUB60: begin
        if (rem_q >= STEP_60) begin
          rem_d = rem_q - STEP_60;
          mu_d  = mu_q + DIG_ONE;
        end else begin
          state_d = SUB10;
        end
      end
      SUB10: begin
        if (rem_q >= STEP_10) begin
          rem_d = rem_q - STEP_10;
          st_d  = st_q + DIG_ONE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (last_time_q >= OVF_LIMIT) begin
          min_tens_d  = DIG_NINE;
          min_units_d = DIG_NINE;
          sec_tens_d  = DIG_FIVE;
          sec_units_d = DIG_NINE;
          overflow_d  = 1'b1;
        end else begin
          min_tens_d  = mt_q;
          min_units_d = mu_q;
          sec_tens_d  = st_q;
          // Remainder is below 10 here, so its low nibble is the units digit
          sec_units_d = rem_q[DIG_W-1:0];
          overflow_d  = 1'b0;
        end
        zero_d  = (last_time_q == TIME_ZERO);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign min_tens  = min_tens_q;
  assign min_units = min_units_q;
  assign sec_tens  = sec_tens_q;
  assign sec_units = sec_units_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: doc/time_digit_decoder.md
TIME_DIGIT_DECODER -- requirements
Module: time_digit_decoder

Interface
REQ-001 The block SHALL have parameter TIME_W, default 16, giving the width of time_in in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port time_in  input  TIME_W  remaining time from the countdown timer, in whole seconds.
REQ-005 The block SHALL have port min_tens  output  4  minutes tens digit, BCD 0..9.
REQ-006 The block SHALL have port min_units  output  4  minutes units digit, BCD 0..9.
REQ-007 The block SHALL have port sec_tens  output  4  seconds tens digit, BCD 0..5.
REQ-008 The block SHALL have port sec_units  output  4  seconds units digit, BCD 0..9.
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse marking an update of the digit outputs.
REQ-010 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-011 The block SHALL have port overflow  output  1  high when the last converted value was 6000 s or more.
REQ-012 The block SHALL have port zero  output  1  high when the last converted value was 0.

Function
REQ-013 The FSM SHALL have the states IDLE, SUB600, SUB60, SUB10 and COMMIT, and SHALL be encoded in registers.
REQ-014 In IDLE, when time_in != last_time on an edge, the block SHALL load rem<=time_in and last_time<=time_in, clear the digit counters, set busy=1, and go to SUB600 (or to COMMIT if time_in>=6000).
REQ-015 In SUB600, each cycle with rem>=600 SHALL subtract 600 and increment mt; when rem<600, the FSM SHALL move to SUB60 with no subtraction.
REQ-016 In SUB60, each cycle with rem>=60 SHALL subtract 60 and increment mu; otherwise the FSM SHALL move to SUB10.
REQ-017 In SUB10, each cycle with rem>=10 SHALL subtract 10 and increment st; otherwise the FSM SHALL move to COMMIT.
REQ-018 In COMMIT, the block SHALL write all four digit outputs atomically (sec_units=rem[3:0]), update overflow and zero, pulse valid for exactly one cycle, clear busy, and return to IDLE.
REQ-019 Overflow handling: for time_in>=6000, COMMIT SHALL output 9,9,5,9 with overflow=1; otherwise overflow=0.
REQ-020 zero SHALL equal 1 exactly when the committed last_time==0.
REQ-021 Latency: for capture on edge E0 with t<6000, valid SHALL be high in the cycle after edge E0+mt+mu+st+4; for t>=6000, valid SHALL be high after edge E0+1.
REQ-022 Changes to time_in while busy=1 SHALL be ignored mid-conversion; the IDLE compare SHALL start a new conversion on the first edge after COMMIT if time_in differs from last_time.
REQ-023 Digit outputs SHALL hold their previous values throughout a conversion and SHALL never show partial results.
REQ-024 Arithmetic: rem SHALL be TIME_W bits wide, the counters SHALL be 4 bits wide, and no subtraction SHALL ever underflow.
REQ-025 If time_in is unchanged, the block SHALL stay in IDLE with no valid pulse.

Reset
REQ-026 Asserting reset SHALL, at any time including mid-conversion, force IDLE with all digits=0, valid=0, busy=0, overflow=0, zero=1, last_time=0, rem=0 and counters=0.
REQ-027 After reset is released, a nonzero time_in SHALL start a conversion on the first rising edge.

Verification
REQ-028 Scenario: reset, then time_in=754 -> busy on the next edge; after 10 cycles valid pulses once with digits 1,2,3,4; overflow=0; zero=0.
REQ-029 Scenario: time_in=5999 -> digits 9,9,5,9 with overflow=0; time_in=6000 -> digits 9,9,5,9 with overflow=1 and valid one cycle after capture.
REQ-030 Scenario: time_in goes 1 -> 0 -> digits 0,0,0,0 with zero=1 and valid pulsed once.
REQ-031 Scenario: time_in changes from 754 to 59 while busy -> first commit is 1,2,3,4, then a second conversion commits 0,0,5,9.
REQ-032 Scenario: reset asserted during SUB60 -> outputs immediately at reset values; after release with time_in=754 held, a fresh conversion yields 1,2,3,4.
REQ-033 Scenario: time_in held constant for 100 cycles after a commit -> no further valid pulse and busy=0 throughout.
